// File: rtl/bm_arb_pkg.sv
// Shared definitions for the busmatrix port arbiter: AHB HTRANS encodings,
// the arbiter state type, the legal port-count set and a one-hot decoder.
package bm_arb_pkg;

    // AHB HTRANS encodings as seen on the selected interface
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // Widest mux the arbiter is allowed to drive
    localparam int MAX_PORTS = 16;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_e;

    // Port counts that map onto a whole number of select bits
    function automatic bit legal_num_ports(input int n);
        return (n == 1) || (n == 2) || (n == 4) || (n == 8) || (n == 16);
    endfunction

    // Binary index of the set bit of a one-hot (or all-zero) vector; zero when empty
    function automatic logic [3:0] onehot_to_idx(input logic [MAX_PORTS-1:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_PORTS; i++) begin
            if (oh[i]) begin
                idx = idx | 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/bm_rr_picker.sv
// Combinational rotating-priority encoder: searches req starting one past the
// pointer, wrapping at the top port, optionally skipping one excluded index.
import bm_arb_pkg::*;

module bm_rr_picker #(
    parameter int NUM_PORTS = 4,
    parameter int IDX_W     = 2
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     pointer,
    input  logic                 excl_en,
    input  logic [IDX_W-1:0]     excl_idx,
    output logic [NUM_PORTS-1:0] winner,
    output logic                 found
);

    logic [IDX_W-1:0] cand;

    // First requester after the pointer wins; the pointer position itself is checked last
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            cand = IDX_W'((int'(pointer) + i) % NUM_PORTS);
            if (!found && req[cand] && !(excl_en && (excl_idx == cand))) begin
                winner[cand] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bm_port_arbiter.sv
// Round-robin arbiter for one busmatrix slave-facing output port.
// Drives the one-hot address-phase and data-phase mux selects; grants only
// move on HREADY and are held for bursts and locked sequences.
// Optional build macro: BM_ARB_PARK_EN parks the grant on port 0 when nobody requests.
import bm_arb_pkg::*;

module bm_port_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int IDX_W     = 2
) (
    input  logic                 hclk,
    input  logic                 hresetn,
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 hready_in,
    input  logic [1:0]           htrans_sel,
    input  logic                 hmastlock_sel,
    output logic [NUM_PORTS-1:0] addr_sel,
    output logic [NUM_PORTS-1:0] data_sel,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 owner_vld
);

    arb_state_e           state_q, state_d;
    logic [NUM_PORTS-1:0] addr_q, addr_d;
    logic [NUM_PORTS-1:0] data_q, data_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;

    logic [NUM_PORTS-1:0] pick_winner;
    logic                 pick_found;
    logic [IDX_W-1:0]     pick_idx;
    logic [IDX_W-1:0]     owner_idx;
    logic                 owner_req;
    logic                 xfer_active;

    assign owner_idx   = IDX_W'(onehot_to_idx(MAX_PORTS'(addr_q)));
    assign pick_idx    = IDX_W'(onehot_to_idx(MAX_PORTS'(pick_winner)));
    assign owner_req   = |(req & addr_q);
    assign xfer_active = (htrans_sel == HTRANS_NONSEQ) || (htrans_sel == HTRANS_SEQ);

    // While someone owns the port, the releasing owner is skipped so others get a turn
    bm_rr_picker #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_picker (
        .req      (req),
        .pointer  (ptr_q),
        .excl_en  (state_q == ARB_OWNED),
        .excl_idx (owner_idx),
        .winner   (pick_winner),
        .found    (pick_found)
    );

    // State register: grant, fairness pointer and data-phase select
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
`ifdef BM_ARB_PARK_EN
            state_q <= ARB_OWNED;
            addr_q  <= MAX_PORTS'(1) == 1 ? NUM_PORTS'(1) : '0;
`else
            state_q <= ARB_IDLE;
            addr_q  <= '0;
`endif
            data_q  <= '0;
            ptr_q   <= IDX_W'(NUM_PORTS - 1);
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next-state logic: everything is frozen unless the selected slave accepts the transfer
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        ptr_d   = ptr_q;
        if (hready_in) begin
            data_d = xfer_active ? addr_q : '0;
            case (state_q)
                ARB_IDLE: begin
                    if (pick_found) begin
                        state_d = ARB_OWNED;
                        addr_d  = pick_winner;
                        ptr_d   = pick_idx;
                    end
                end
                ARB_OWNED: begin
                    if (!owner_req && !hmastlock_sel) begin
                        if (pick_found) begin
                            addr_d = pick_winner;
                            ptr_d  = pick_idx;
                        end else begin
`ifdef BM_ARB_PARK_EN
                            addr_d    = '0;
                            addr_d[0] = 1'b1;
`else
                            state_d = ARB_IDLE;
                            addr_d  = '0;
`endif
                        end
                    end
                end
                default: begin
                    state_d = ARB_IDLE;
                    addr_d  = '0;
                end
            endcase
        end
    end

    // Outputs come straight from registers so the mux selects are glitch-free
    always_comb begin
        addr_sel  = addr_q;
        data_sel  = data_q;
        grant_idx = owner_idx;
        owner_vld = |addr_q;
    end

endmodule

// File: tb/tb_bm_port_arbiter.sv
// Self-checking bench for bm_port_arbiter (default build, 4 ports): a few
// directed scenarios with fixed expectations, then randomized traffic checked
// against a behavioural round-robin model.
module tb_bm_port_arbiter;

    logic       hclk;
    logic       hresetn;
    logic [3:0] req;
    logic       hready_in;
    logic [1:0] htrans_sel;
    logic       hmastlock_sel;
    logic [3:0] addr_sel;
    logic [3:0] data_sel;
    logic [1:0] grant_idx;
    logic       owner_vld;

    int compared;
    int mismatched;

    // Reference model state: owner/data owner as port numbers, -1 = nobody
    int mOwner;
    int mPtr;
    int mData;

    bm_port_arbiter #(
        .NUM_PORTS (4),
        .IDX_W     (2)
    ) dut (
        .hclk          (hclk),
        .hresetn       (hresetn),
        .req           (req),
        .hready_in     (hready_in),
        .htrans_sel    (htrans_sel),
        .hmastlock_sel (hmastlock_sel),
        .addr_sel      (addr_sel),
        .data_sel      (data_sel),
        .grant_idx     (grant_idx),
        .owner_vld     (owner_vld)
    );

    // Free-running bus clock
    initial begin
        hclk = 1'b0;
        forever #5 hclk = ~hclk;
    end

    // Count one comparison and report it if it disagrees
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Rotating search from pointer+1, skipping excl (-1 = none)
    function automatic int modelPick(input logic [3:0] r, input int p, input int excl);
        int c;
        for (int k = 1; k <= 4; k++) begin
            c = (p + k) % 4;
            if (r[c[1:0]] && c != excl) return c;
        end
        return -1;
    endfunction

    // Advance the reference model by one clock using the inputs present at the edge
    task automatic modelStep();
        int w;
        if (!hresetn) begin
            mOwner = -1;
            mPtr   = 3;
            mData  = -1;
        end else if (hready_in) begin
            mData = htrans_sel[1] ? mOwner : -1;
            if (mOwner < 0) begin
                w = modelPick(req, mPtr, -1);
                if (w >= 0) begin
                    mOwner = w;
                    mPtr   = w;
                end
            end else if (!req[mOwner[1:0]] && !hmastlock_sel) begin
                w = modelPick(req, mPtr, mOwner);
                if (w >= 0) begin
                    mOwner = w;
                    mPtr   = w;
                end else begin
                    mOwner = -1;
                end
            end
        end
    endtask

    function automatic logic [31:0] oneHot(input int p);
        return (p < 0) ? 32'd0 : (32'd1 << p);
    endfunction

    // Drive one cycle of inputs, clock it, then compare DUT against the model mid-cycle
    task automatic applyStimulus(input logic rstn, input logic [3:0] r, input logic hr,
                                 input logic [1:0] ht, input logic lk);
        hresetn       = rstn;
        req           = r;
        hready_in     = hr;
        htrans_sel    = ht;
        hmastlock_sel = lk;
        @(posedge hclk);
        modelStep();
        @(negedge hclk);
        checkOutput("model_addr_sel", 32'(addr_sel), oneHot(mOwner));
        checkOutput("model_data_sel", 32'(data_sel), oneHot(mData));
        checkOutput("model_grant_idx", 32'(grant_idx), (mOwner < 0) ? 32'd0 : 32'(mOwner));
        checkOutput("model_owner_vld", 32'(owner_vld), (mOwner < 0) ? 32'd0 : 32'd1);
    endtask

    initial begin
        logic [3:0] r;
        compared   = 0;
        mismatched = 0;
        mOwner     = -1;
        mPtr       = 3;
        mData      = -1;

        // Reset state
        applyStimulus(1'b0, 4'b0000, 1'b1, 2'b00, 1'b0);
        applyStimulus(1'b0, 4'b0000, 1'b1, 2'b00, 1'b0);
        checkOutput("rst_addr_sel", 32'(addr_sel), 32'd0);
        checkOutput("rst_data_sel", 32'(data_sel), 32'd0);
        checkOutput("rst_owner_vld", 32'(owner_vld), 32'd0);

        // First grant goes to port 1 after one cycle
        applyStimulus(1'b1, 4'b0110, 1'b1, 2'b00, 1'b0);
        checkOutput("first_addr_sel", 32'(addr_sel), 32'h2);
        checkOutput("first_grant_idx", 32'(grant_idx), 32'd1);
        checkOutput("first_data_sel", 32'(data_sel), 32'd0);

        // Port 1 releases while others request: handover to port 2, data still on port 1
        applyStimulus(1'b1, 4'b1101, 1'b1, 2'b10, 1'b0);
        checkOutput("handover_addr_sel", 32'(addr_sel), 32'h4);
        checkOutput("handover_data_sel", 32'(data_sel), 32'h2);

        // Wait states freeze everything even though port 2 released
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 4'b1001, 1'b0, 2'b10, 1'b0);
            checkOutput("freeze_addr_sel", 32'(addr_sel), 32'h4);
            checkOutput("freeze_data_sel", 32'(data_sel), 32'h2);
        end
        applyStimulus(1'b1, 4'b1001, 1'b1, 2'b10, 1'b0);
        checkOutput("unfreeze_addr_sel", 32'(addr_sel), 32'h8);
        checkOutput("unfreeze_data_sel", 32'(data_sel), 32'h4);

        // Locked sequence holds port 3 despite its request dropping
        applyStimulus(1'b1, 4'b0001, 1'b1, 2'b11, 1'b1);
        checkOutput("lock_addr_sel", 32'(addr_sel), 32'h8);
        checkOutput("lock_data_sel", 32'(data_sel), 32'h8);

        // Lock released: pointer wraps 3 -> 0, IDLE transfer gives no data phase
        applyStimulus(1'b1, 4'b0001, 1'b1, 2'b00, 1'b0);
        checkOutput("wrap_addr_sel", 32'(addr_sel), 32'h1);
        checkOutput("wrap_grant_idx", 32'(grant_idx), 32'd0);
        checkOutput("wrap_data_sel", 32'(data_sel), 32'd0);

        // Nobody requesting: port goes idle
        applyStimulus(1'b1, 4'b0000, 1'b1, 2'b00, 1'b0);
        checkOutput("idle_owner_vld", 32'(owner_vld), 32'd0);

        // Randomized traffic with burst-like requests, wait states, locks and resets
        r = 4'b0000;
        for (int n = 0; n < 2000; n++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
            end
            applyStimulus(($urandom_range(0, 99) != 0),
                          r,
                          ($urandom_range(0, 3) != 0),
                          2'($urandom_range(0, 3)),
                          ($urandom_range(0, 9) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
